// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, PC source encodings and
// the opcode values the control decoder also uses.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus: decoded hazard inputs from the pipeline and the
// per-stage enable/flush/PC-select outputs back to it.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_j;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic       mem_access;
  logic       dmem_ready;

  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ifid_we;
  logic       idex_we;
  logic       exmem_we;
  logic       memwb_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_j, ex_memread, ex_rt,
           mem_branch_taken, mem_access, dmem_ready,
    input  pc_we, pc_sel, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_j, ex_memread, ex_rt,
           mem_branch_taken, mem_access, dmem_ready,
    output pc_we, pc_sel, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (inc && !(&q))
      q <= q + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage MIPS hazard controller: memory wait states with timeout-to-halt,
// branch/jump redirects, load-use bubbles, plus stall/redirect counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       mem_stall;
  logic       do_rules;
  logic       redirect;
  logic       stall_inc;

  // A load into $0 never produces a value anyone waits for.
  assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign mem_stall = bus.mem_access && !bus.dmem_ready;

  always_comb begin
    bus.pc_we       = 1'b1;
    bus.pc_sel      = PC_SEL_SEQ;
    bus.ifid_we     = 1'b1;
    bus.idex_we     = 1'b1;
    bus.exmem_we    = 1'b1;
    bus.memwb_we    = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    redirect        = 1'b0;
    do_rules        = 1'b0;
    if (reset) begin
      bus.pc_we    = 1'b0;
      bus.ifid_we  = 1'b0;
      bus.idex_we  = 1'b0;
      bus.exmem_we = 1'b0;
      bus.memwb_we = 1'b0;
    end else begin
      case (state)
        RUN:     do_rules = !mem_stall;
        MEMWAIT: do_rules = bus.dmem_ready;
        default: do_rules = 1'b0;
      endcase
      if (!do_rules) begin
        bus.pc_we    = 1'b0;
        bus.ifid_we  = 1'b0;
        bus.idex_we  = 1'b0;
        bus.exmem_we = 1'b0;
        bus.memwb_we = 1'b0;
      end else if (bus.mem_branch_taken) begin
        // Branch resolves in MEM, so the three younger instructions are wrong-path.
        bus.pc_sel      = PC_SEL_BRANCH;
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_flush = 1'b1;
        redirect        = 1'b1;
      end else if (load_use) begin
        bus.pc_we      = 1'b0;
        bus.ifid_we    = 1'b0;
        bus.idex_flush = 1'b1;
      end else if (bus.id_j) begin
        bus.pc_sel     = PC_SEL_JUMP;
        bus.ifid_flush = 1'b1;
        redirect       = 1'b1;
      end
    end
  end

  // Wait counter holds the number of frozen cycles already spent on this access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEMWAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEMWAIT: begin
          if (bus.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted    = (state == HALT);
  assign stall_inc = !bus.pc_we && !reset && (state != HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .q     (redirect_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: a default instance plus a MEM_TIMEOUT=3, CNT_W=4
// instance driven with identical stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus_a ();
  pipe_hazard_ctrl_if bus_b ();

  logic        halted_a;
  logic        halted_b;
  logic [15:0] stall_a;
  logic [15:0] redir_a;
  logic [3:0]  stall_b;
  logic [3:0]  redir_b;

  pipe_hazard_ctrl dut_a (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_a.slave),
    .halted         (halted_a),
    .stall_cycles   (stall_a),
    .redirect_count (redir_a)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(4)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_b.slave),
    .halted         (halted_b),
    .stall_cycles   (stall_b),
    .redirect_count (redir_b)
  );

  // {pc_we, pc_sel[1:0], ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, exmem_flush}
  localparam logic [9:0] CTL_ZERO   = 10'b0_00_0000_000;
  localparam logic [9:0] CTL_NORMAL = 10'b1_00_1111_000;
  localparam logic [9:0] CTL_BRANCH = 10'b1_10_1111_111;
  localparam logic [9:0] CTL_LDUSE  = 10'b0_00_0111_010;
  localparam logic [9:0] CTL_JUMP   = 10'b1_01_1111_100;

  logic [9:0] ctl_a;
  logic [9:0] ctl_b;

  assign ctl_a = {bus_a.pc_we, bus_a.pc_sel, bus_a.ifid_we, bus_a.idex_we, bus_a.exmem_we,
                  bus_a.memwb_we, bus_a.ifid_flush, bus_a.idex_flush, bus_a.exmem_flush};
  assign ctl_b = {bus_b.pc_we, bus_b.pc_sel, bus_b.ifid_we, bus_b.idex_we, bus_b.exmem_we,
                  bus_b.memwb_we, bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_flush};

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic j, input logic memread, input logic [4:0] ert,
                               input logic br, input logic access, input logic ready);
    bus_a.id_rs = rs;            bus_b.id_rs = rs;
    bus_a.id_rt = rt;            bus_b.id_rt = rt;
    bus_a.id_uses_rt = uses_rt;  bus_b.id_uses_rt = uses_rt;
    bus_a.id_j = j;              bus_b.id_j = j;
    bus_a.ex_memread = memread;  bus_b.ex_memread = memread;
    bus_a.ex_rt = ert;           bus_b.ex_rt = ert;
    bus_a.mem_branch_taken = br; bus_b.mem_branch_taken = br;
    bus_a.mem_access = access;   bus_b.mem_access = access;
    bus_a.dmem_ready = ready;    bus_b.dmem_ready = ready;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    checkOutput("reset_ctl", 32'(ctl_a), 32'(CTL_ZERO));
    checkOutput("reset_halted", 32'(halted_a), 32'd0);
    checkOutput("reset_stall", 32'(stall_a), 32'd0);
    checkOutput("reset_redirect", 32'(redir_a), 32'd0);

    @(negedge clk); reset = 1'b0; idle(); #1;
    checkOutput("idle_ctl", 32'(ctl_a), 32'(CTL_NORMAL));

    // Load-use on rs
    @(negedge clk); applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("lduse_rs_ctl", 32'(ctl_a), 32'(CTL_LDUSE));
    @(negedge clk); idle(); #1;
    checkOutput("lduse_after_ctl", 32'(ctl_a), 32'(CTL_NORMAL));
    checkOutput("lduse_stall", 32'(stall_a), 32'd1);

    // Load into $0 never stalls
    @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("lduse_r0_ctl", 32'(ctl_a), 32'(CTL_NORMAL));

    // Load-use on rt only counts when ID actually reads rt
    @(negedge clk); applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("lduse_rt_ctl", 32'(ctl_a), 32'(CTL_LDUSE));
    checkOutput("lduse_r0_stall", 32'(stall_a), 32'd1);
    @(negedge clk); applyStimulus(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("rt_unused_ctl", 32'(ctl_a), 32'(CTL_NORMAL));
    checkOutput("lduse_rt_stall", 32'(stall_a), 32'd2);

    // Branch beats jump and load-use in the same cycle
    @(negedge clk); applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1); #1;
    checkOutput("branch_ctl", 32'(ctl_a), 32'(CTL_BRANCH));
    @(negedge clk); idle(); #1;
    checkOutput("branch_redirect", 32'(redir_a), 32'd1);
    checkOutput("branch_stall", 32'(stall_a), 32'd2);

    // Jump alone
    @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("jump_ctl", 32'(ctl_a), 32'(CTL_JUMP));
    @(negedge clk); idle(); #1;
    checkOutput("jump_after_ctl", 32'(ctl_a), 32'(CTL_NORMAL));
    checkOutput("jump_redirect", 32'(redir_a), 32'd2);

    // Four frozen cycles; the small instance times out on the fourth
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
      checkOutput($sformatf("memwait_a_%0d", i), 32'(ctl_a), 32'(CTL_ZERO));
      checkOutput($sformatf("memwait_b_%0d", i), 32'(ctl_b), 32'(CTL_ZERO));
    end
    @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); #1;
    checkOutput("memready_ctl_a", 32'(ctl_a), 32'(CTL_NORMAL));
    checkOutput("halt_ctl_b", 32'(ctl_b), 32'(CTL_ZERO));
    checkOutput("halted_a", 32'(halted_a), 32'd0);
    checkOutput("halted_b", 32'(halted_b), 32'd1);
    checkOutput("memwait_stall_a", 32'(stall_a), 32'd6);
    checkOutput("memwait_stall_b", 32'(stall_b), 32'd6);
    @(negedge clk); idle(); #1;
    checkOutput("run_again_ctl_a", 32'(ctl_a), 32'(CTL_NORMAL));
    checkOutput("halt_hold_ctl_b", 32'(ctl_b), 32'(CTL_ZERO));
    checkOutput("halt_stall_b", 32'(stall_b), 32'd6);

    // Asynchronous reset between clock edges clears the halt
    #2 reset = 1'b1;
    #1;
    checkOutput("async_halted_b", 32'(halted_b), 32'd0);
    checkOutput("async_stall_a", 32'(stall_a), 32'd0);
    checkOutput("async_redirect_a", 32'(redir_a), 32'd0);
    checkOutput("async_ctl_a", 32'(ctl_a), 32'(CTL_ZERO));
    @(negedge clk); reset = 1'b0; idle(); #1;
    checkOutput("post_reset_ctl_b", 32'(ctl_b), 32'(CTL_NORMAL));
    checkOutput("post_reset_stall_b", 32'(stall_b), 32'd0);

    // Reset in the middle of MEMWAIT returns to RUN
    @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
    checkOutput("mw_entry_ctl", 32'(ctl_a), 32'(CTL_ZERO));
    @(negedge clk); #1;
    checkOutput("mw_stall_a", 32'(stall_a), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mw_reset_ctl", 32'(ctl_a), 32'(CTL_ZERO));
    checkOutput("mw_reset_stall", 32'(stall_a), 32'd0);
    @(negedge clk); reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    checkOutput("mw_release_ctl", 32'(ctl_a), 32'(CTL_NORMAL));

    // Twenty back-to-back load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1); #1;
      checkOutput($sformatf("sat_ctl_%0d", i), 32'(ctl_b), 32'(CTL_LDUSE));
    end
    @(negedge clk); idle(); #1;
    checkOutput("sat_stall_b", 32'(stall_b), 32'd15);
    checkOutput("sat_stall_a", 32'(stall_a), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) around the decoded control bundle.
- Generates per-stage write-enable and flush/bubble signals and the PC source select for four conditions: data-memory wait states, taken branches, load-use hazards and jumps.
- Holds a small FSM for memory wait with a timeout-to-halt.
- Keeps saturating stall and redirect performance counters.
- Sits beside the control decoder and drives the pipeline register enables.

Parameters:
- MEM_TIMEOUT, 15: max consecutive wait cycles in MEMWAIT before HALT (range 1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, sw, beq, bne)
- id_j  in  1  jump decoded in ID
- ex_memread  in  1  instruction in EX is a load (M memread bit)
- ex_rt  in  5  destination rt of instruction in EX
- mem_branch_taken  in  1  branch in MEM resolved taken: (beq & zero) | (bne & ~zero)
- mem_access  in  1  instruction in MEM is lw or sw
- dmem_ready  in  1  data memory completes access this cycle
- pc_we  out  1  PC update enable
- pc_sel  out  2  0 = PC+4, 1 = jump target, 2 = branch target
- ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a zero control bundle (bubble) instead of the incoming data
- halted  out  1  sticky; pipeline stopped on memory timeout
- stall_cycles  out  CNT_W  cycles with pc_we=0 outside HALT, saturating
- redirect_count  out  CNT_W  taken branches plus jumps, saturating

Behaviour:
- States: RUN, MEMWAIT, HALT.
  - State, wait counter and perf counters are registered.
  - All other outputs are combinational from state and inputs (Mealy).
- Reset while asserted (any time, including mid-MEMWAIT):
  - state = RUN, wait counter = 0, counters = 0, halted = 0.
  - All enables 0, all flushes 0, pc_sel = 0.
- Default (no condition): all *_we = 1, pc_we = 1, flushes = 0, pc_sel = 0.
- RUN evaluation, strict priority, first match wins:
  1. mem_access & ~dmem_ready:
     - All enables and pc_we = 0, flushes = 0.
     - Next state MEMWAIT, wait counter = 1.
  2. mem_branch_taken:
     - pc_sel = 2, pc_we = 1.
     - ifid_flush = idex_flush = exmem_flush = 1, which squashes the 3 younger instructions.
     - Enables otherwise 1; redirect_count += 1.
  3. Load-use: ex_memread & ex_rt != 0 & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)):
     - pc_we = 0, ifid_we = 0, idex_flush = 1; other enables 1.
     - Lasts exactly one cycle, because the bubble clears the condition.
  4. id_j:
     - pc_sel = 1, pc_we = 1, ifid_flush = 1; redirect_count += 1.
- MEMWAIT:
  - If dmem_ready = 0:
    - Full freeze (all enables 0).
    - If wait counter == MEM_TIMEOUT, next state HALT; else wait counter += 1.
  - If dmem_ready = 1: outputs follow RUN rules 2..4 with rule 1 suppressed; next state RUN.
- HALT:
  - All enables 0, flushes 0, halted = 1.
  - Exit only by reset; inputs are ignored.
- stall_cycles:
  - Increments every cycle with pc_we = 0 in RUN or MEMWAIT.
  - Covers load-use, the MEMWAIT entry cycle and MEMWAIT wait cycles.
- Both counters saturate at all-ones; there is no wrap.
- A branch flush and a jump in ID in the same cycle: branch wins and the jump is squashed; count +1 only.
- Load-use and a taken branch in the same cycle: branch wins, no stall is counted.
- Register $0 as a load destination never stalls.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, MEMWAIT, HALT};
  - PC_SEL_SEQ = 0, PC_SEL_JUMP = 1, PC_SEL_BRANCH = 2;
  - opcode constants (R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02) shared with the decoder.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output q), instanced twice.

Test Plan:
- Load-use: ex_memread = 1, ex_rt = 8, id_rs = 8 -> one cycle with pc_we = 0, ifid_we = 0, idex_flush = 1; next cycle normal; stall_cycles = 1. Same with ex_rt = 0 -> no stall.
- Taken branch with id_j = 1 and the load-use condition also true -> pc_sel = 2, three flushes = 1, redirect_count = 1, stall_cycles = 0.
- Jump alone -> pc_sel = 1, ifid_flush = 1 for one cycle, redirect_count increments by 1.
- mem_access = 1, dmem_ready low for 4 cycles then high -> all enables 0 for 4 cycles (stall_cycles = 4), returns to RUN, normal flow on the 5th cycle.
- MEM_TIMEOUT = 3, dmem_ready held low -> HALT entered after the 4th frozen cycle, halted = 1 thereafter; reset pulse -> RUN, counters 0.
- Reset asserted mid-MEMWAIT -> outputs go to reset values immediately (async); after release, state = RUN. Also: CNT_W = 4 with 20 stalls -> stall_cycles = 15.
